// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: word size, FSM encoding,
// byte-lane enables and sign-extended byte extraction (little-endian lanes).
package data_mem_responder_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } memr_state_e;

  function automatic logic [3:0] lane_byte_en(input logic is_byte, input logic [1:0] lane);
    return is_byte ? 4'(4'b0001 << lane) : 4'hF;
  endfunction

  function automatic logic [WORD_SIZE-1:0] lane_sext(input logic [WORD_SIZE-1:0] word,
                                                     input logic [1:0] lane);
    logic [7:0] b;
    b = word[8*lane +: 8];
    return {{(WORD_SIZE-8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the memory stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic                 req_byte;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word-organised data RAM: one synchronous write port with per-byte enables and a
// combinational read on the same address. Contents are not reset.
module data_mem_responder_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic [WORD_SIZE-1:0]  rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [WORD_SIZE-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder: latches one request, waits LATENCY cycles,
// performs the word/byte access with alignment and range checking, holds the response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  memr_state_e          state_q;
  logic [3:0]           cnt_q;
  logic                 wr_q;
  logic                 byte_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;

  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  access_err;
  logic                  do_access;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [WORD_SIZE-1:0]  mem_rdata;
  logic [WORD_SIZE-1:0]  load_data;

  always_comb begin
    lane         = addr_q[1:0];
    word_idx     = addr_q[ADDR_WIDTH+1:2];
    misaligned   = !byte_q && (lane != 2'b00);
    // Any set bit above the word index means the byte address lies beyond the array.
    out_of_range = (addr_q >> (ADDR_WIDTH + 2)) != '0;
    access_err   = misaligned || out_of_range;
    do_access    = (state_q == StWait) && (cnt_q == 4'd0);
    mem_we       = do_access && wr_q && !access_err;
    mem_be       = lane_byte_en(byte_q, lane);
    mem_wdata    = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    load_data    = byte_q ? lane_sext(mem_rdata, lane) : mem_rdata;
  end

  data_mem_responder_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (word_idx),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            wr_q        <= bus.req_write;
            byte_q      <= bus.req_byte;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            cnt_q       <= CntInit;
            req_ready_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q     <= (wr_q || access_err) ? '0 : load_data;
            err_q       <= access_err;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          // No request is taken in the same cycle the response retires.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// load/store traffic checked against a byte-addressed reference memory.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned AW     = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned NBYTES = 4 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_mem_responder_if bus();

  data_mem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: one entry per byte, little-endian.
  logic [7:0] model [NBYTES];

  function automatic logic model_err(input logic b, input logic [31:0] a);
    return (!b && (a[1:0] != 2'b00)) || (a >= 32'(NBYTES));
  endfunction

  function automatic logic [31:0] model_load(input logic b, input logic [31:0] a);
    if (model_err(b, a)) return 32'h0;
    if (b) return {{24{model[a][7]}}, model[a]};
    return {model[a+3], model[a+2], model[a+1], model[a]};
  endfunction

  function automatic void model_store(input logic b, input logic [31:0] a, input logic [31:0] d);
    if (model_err(b, a)) return;
    if (b) model[a] = d[7:0];
    else for (int i = 0; i < 4; i++) model[a+i] = d[8*i +: 8];
  endfunction

  // One transaction with rsp_ready held high; entered and left at posedge+1.
  task automatic run_op(input string name, input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    exp_err = model_err(b, a);
    exp_rd  = (w || exp_err) ? 32'h0 : model_load(b, a);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready before issue: got %b want 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte  = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk); #1;
    // Scramble request fields after the accept edge; they must be ignored.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_byte  = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    rd = bus.rsp_rdata;
    n_checks++;
    if (bus.rsp_rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h", name, bus.rsp_rdata, exp_rd);
    end
    n_checks++;
    if (bus.rsp_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b", name, bus.rsp_err, exp_err);
    end
    if (w) model_store(b, a, d);
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s retire: got valid=%b ready=%b want valid=0 ready=1", name,
               bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset rsp data: got rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd;
    run_op("word_store_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    run_op("word_store_20", 1'b1, 1'b0, 32'h20, 32'hCAFE1234, rd);
    run_op("word_store_00", 1'b1, 1'b0, 32'h00, 32'h13572468, rd);
    run_op("word_load_10", 1'b0, 1'b0, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_load_const: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_load();
    logic [31:0] rd;
    logic [31:0] exp [4];
    exp = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE};
    for (int i = 0; i < 4; i++) begin
      run_op("byte_load", 1'b0, 1'b1, 32'h10 + 32'(i), 32'h0, rd);
      n_checks++;
      if (rd !== exp[i]) begin
        n_fail++; $display("FAIL byte_load_const lane %0d: got %h want %h", i, rd, exp[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    run_op("byte_store_12", 1'b1, 1'b1, 32'h12, {24'($urandom), 8'h7F}, rd);
    run_op("word_after_bstore", 1'b0, 1'b0, 32'h10, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hDE7FBEEF) begin
      n_fail++; $display("FAIL byte_store_word_const: got %h want de7fbeef", rd);
    end
    run_op("byte_after_bstore", 1'b0, 1'b1, 32'h12, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000007F) begin
      n_fail++; $display("FAIL byte_store_byte_const: got %h want 0000007f", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    run_op("misaligned_load", 1'b0, 1'b0, 32'h11, 32'h0, rd);
    run_op("oor_store", 1'b1, 1'b0, 32'(4 << AW), 32'h1, rd);
    run_op("oor_byte_load", 1'b0, 1'b1, 32'(NBYTES), 32'h0, rd);
    run_op("misaligned_store", 1'b1, 1'b0, 32'h02, 32'hFFFFFFFF, rd);
    run_op("load_00", 1'b0, 1'b0, 32'h00, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h13572468) begin
      n_fail++; $display("FAIL err_no_corrupt: got %h want 13572468", rd);
    end
    run_op("top_word_store", 1'b1, 1'b0, 32'(NBYTES - 4), 32'hA5A55A5A, rd);
    run_op("top_byte_load", 1'b0, 1'b1, 32'(NBYTES - 1), 32'h0, rd);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [31:0] exp_rd;
    int          lat;
    exp_rd = model_load(1'b0, 32'h10);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    held = bus.rsp_rdata;
    n_checks++;
    if (lat != LAT || held !== exp_rd) begin
      n_fail++;
      $display("FAIL bp_response: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, held, LAT,
               exp_rd);
    end
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got valid=%b rdata=%h ready=%b want 1/%h/0", i,
                 bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held);
      end
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored_req: got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    run_op("pre_reset_load", 1'b0, 1'b0, 32'h10, 32'h0, rd);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h00000055;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
        bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op("load_after_reset", 1'b0, 1'b0, 32'h20, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hCAFE1234) begin
      n_fail++; $display("FAIL dropped_store: got %h want cafe1234", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic        w;
    logic        b;
    int          r;
    for (int i = 64; i < 128; i++) run_op("rand_fill", 1'b1, 1'b0, 32'(i * 4), $urandom, rd);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(99));
      w = 1'($urandom);
      b = 1'($urandom);
      a = 32'h100 + 32'($urandom_range(255));
      if (r < 5) a = $urandom | 32'h1000;
      else if (!b && r >= 15) a[1:0] = 2'b00;
      run_op("random", w, b, a, $urandom, rd);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_word();
    test_byte_load();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
